// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the neuron building blocks.
//   - default data / fractional widths
//   - neuron FSM state encoding
//   - signed saturation bounds for an arbitrary output width
package nn_pkg;

   localparam int unsigned NN_DATA_W = 8;
   localparam int unsigned NN_FRAC_W = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } nn_state_e;

   // Largest value representable in a signed field of the given width
   function automatic logic signed [63:0] sat_max(input int unsigned width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   // Smallest value representable in a signed field of the given width
   function automatic logic signed [63:0] sat_min(input int unsigned width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/nn_saturate.sv
// nn_saturate: combinational signed clip from IN_W bits down to OUT_W bits.
// Ports:
//   sum_i  in  IN_W   signed value to clip
//   out_c  out OUT_W  clipped value (two's complement)
//   sat_c  out 1      set when sum_i lay outside the OUT_W signed range
module nn_saturate
   import nn_pkg::*;
#(
   parameter int unsigned IN_W  = 18,
   parameter int unsigned OUT_W = 8
) (
   input  logic signed [IN_W-1:0]  sum_i,
   output logic        [OUT_W-1:0] out_c,
   output logic                    sat_c
);

   localparam logic signed [IN_W-1:0] MAX_V = IN_W'(sat_max(OUT_W));
   localparam logic signed [IN_W-1:0] MIN_V = IN_W'(sat_min(OUT_W));

   // Clip to the representable range, flagging any clipping
   always_comb begin
      out_c = sum_i[OUT_W-1:0];
      sat_c = 1'b0;
      if (sum_i > MAX_V) begin
         out_c = MAX_V[OUT_W-1:0];
         sat_c = 1'b1;
      end else if (sum_i < MIN_V) begin
         out_c = MIN_V[OUT_W-1:0];
         sat_c = 1'b1;
      end
   end

endmodule

// File: rtl/mac_neuron.sv
// mac_neuron: sequential fixed-point neuron. Accumulates N_IN signed w*x
// products, scales by FRAC_W (floor), adds bias, saturates to DATA_W.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input pair handshake (w, x; b on first pair)
//   w, x, b               signed weight, input, bias
//   out_valid / out_ready result handshake
//   out, sat              signed saturated result and clip flag
module mac_neuron
   import nn_pkg::*;
#(
   parameter int unsigned DATA_W = NN_DATA_W,
   parameter int unsigned FRAC_W = NN_FRAC_W,
   parameter int unsigned N_IN   = 4,
   parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N_IN) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] w,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out,
   output logic              sat
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

   nn_state_e state_q, state_d;

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic        [CNT_W-1:0]  cnt_q, cnt_d;
   logic signed [DATA_W-1:0] b_q, b_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic        [DATA_W-1:0] out_q, out_d;
   logic                     sat_q, sat_d;

   logic                     accept, first, last;
   logic signed [PROD_W-1:0] w_ext, x_ext, prod;
   logic signed [ACC_W-1:0]  prod_ext, acc_next, acc_shift;
   logic signed [DATA_W-1:0] b_next;
   logic signed [SUM_W-1:0]  sum;
   logic        [DATA_W-1:0] sat_out;
   logic                     sat_flag;

   assign accept = in_valid && in_ready_q;
   assign first  = (state_q == IDLE);
   assign last   = (cnt_q == CNT_LAST);

   // Full-precision signed product, sign-extended into the accumulator
   assign w_ext    = {{DATA_W{w[DATA_W-1]}}, w};
   assign x_ext    = {{DATA_W{x[DATA_W-1]}}, x};
   assign prod     = w_ext * x_ext;
   assign prod_ext = ACC_W'(prod);

   // First pair of a group overwrites the accumulator and captures the bias
   assign acc_next = first ? prod_ext : acc_q + prod_ext;
   assign b_next   = first ? b : b_q;

   // Arithmetic shift floors toward -inf; the result is formed from the
   // post-accept values so it is ready the cycle after the last pair
   assign acc_shift = acc_next >>> FRAC_W;
   assign sum       = SUM_W'(acc_shift) + SUM_W'(b_next);

   nn_saturate #(
      .IN_W  (SUM_W),
      .OUT_W (DATA_W)
   ) u_sat (
      .sum_i (sum),
      .out_c (sat_out),
      .sat_c (sat_flag)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ACCUM: if (accept) state_d = last ? DONE : ACCUM;
         DONE:        if (out_valid_q && out_ready) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      b_d         = b_q;
      out_d       = out_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      in_ready_d  = (state_d != DONE);
      if (accept) begin
         acc_d = acc_next;
         b_d   = b_next;
         cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      end
      if (accept && last) begin
         out_valid_d = 1'b1;
         out_d       = sat_out;
         sat_d       = sat_flag;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         b_q         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         sat_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         b_q         <= b_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         sat_q       <= sat_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign sat       = sat_q;

endmodule
